// File: rtl/pmc_report_streamer.sv
// pmc_report_streamer: snapshots the four performance-metric buses on a
// trigger and streams them as a fixed byte frame (sync, payload, XOR
// checksum) over a valid/ready byte interface toward the UART transmitter.
module pmc_report_streamer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trigger_in,
    input  logic [255:0] stall_count_in,
    input  logic [255:0] cpi_q78_in,
    input  logic [255:0] arith_count_in,
    input  logic [255:0] mem_access_count_in,
    input  logic         tx_ready_in,
    output logic         tx_valid_out,
    output logic [7:0]   tx_data_out,
    output logic         busy_out,
    output logic         done_out,
    output logic         overflow_out,
    output logic         missed_trigger_out
);

    localparam int unsigned W         = WORD_BYTES * 8;
    localparam int unsigned PAY_BYTES = 4 * WORD_BYTES;
    localparam int unsigned FRAME_LEN = 2 + PAY_BYTES;
    localparam int unsigned IDXW      = 6;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDXW-1:0]        idx;
    logic [PAY_BYTES*8-1:0] payload;
    logic [7:0]             checksum;
    logic                   overflow;
    logic                   missed;
    logic                   snap;
    logic                   handshake;
    logic [7:0]             pay_byte;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        handshake = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger_in) begin
                    snap      = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                handshake = tx_ready_in;
                if (tx_ready_in && (idx == LAST_IDX)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Payload byte selected by the frame index (payload starts at index 1, MSB byte first)
    always_comb begin
        pay_byte = '0;
        for (int unsigned i = 0; i < PAY_BYTES; i++) begin
            if (idx == IDXW'(i + 1)) begin
                pay_byte = payload[(PAY_BYTES - 1 - i) * 8 +: 8];
            end
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        tx_valid_out       = (state == S_SEND);
        busy_out           = (state == S_SEND) || (state == S_DONE);
        done_out           = (state == S_DONE);
        overflow_out       = overflow;
        missed_trigger_out = missed;
        tx_data_out        = '0;
        if (state == S_SEND) begin
            if (idx == '0) begin
                tx_data_out = SYNC_BYTE;
            end else if (idx == LAST_IDX) begin
                tx_data_out = checksum;
            end else begin
                tx_data_out = pay_byte;
            end
        end
    end

    // Snapshot, byte index, running checksum and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            payload  <= '0;
            checksum <= '0;
            overflow <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (snap) begin
                payload  <= {stall_count_in[W-1:0], cpi_q78_in[W-1:0],
                             arith_count_in[W-1:0], mem_access_count_in[W-1:0]};
                overflow <= (|stall_count_in[255:W]) | (|cpi_q78_in[255:W]) |
                            (|arith_count_in[255:W]) | (|mem_access_count_in[255:W]);
                idx      <= '0;
                checksum <= '0;
            end else if (handshake) begin
                idx <= idx + 1'b1;
                if ((idx != '0) && (idx != LAST_IDX)) begin
                    checksum <= checksum ^ pay_byte;
                end
            end
            if (trigger_in && (state != S_IDLE)) begin
                missed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pmc_report_streamer.sv
// Directed bench for pmc_report_streamer: expected frame bytes are queued
// when a trigger is driven and compared as each handshake occurs.
module tb_pmc_report_streamer;

    localparam int unsigned WB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         trigger_in;
    logic [255:0] stall_count_in;
    logic [255:0] cpi_q78_in;
    logic [255:0] arith_count_in;
    logic [255:0] mem_access_count_in;
    logic         tx_ready_in;
    logic         tx_valid_out;
    logic [7:0]   tx_data_out;
    logic         busy_out;
    logic         done_out;
    logic         overflow_out;
    logic         missed_trigger_out;

    pmc_report_streamer #(.WORD_BYTES(WB), .SYNC_BYTE(8'hA5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .trigger_in          (trigger_in),
        .stall_count_in      (stall_count_in),
        .cpi_q78_in          (cpi_q78_in),
        .arith_count_in      (arith_count_in),
        .mem_access_count_in (mem_access_count_in),
        .tx_ready_in         (tx_ready_in),
        .tx_valid_out        (tx_valid_out),
        .tx_data_out         (tx_data_out),
        .busy_out            (busy_out),
        .done_out            (done_out),
        .overflow_out        (overflow_out),
        .missed_trigger_out  (missed_trigger_out)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          done_cnt;
    int          starts_seen;
    int          start_cyc[$];
    logic [7:0]  exp_q[$];
    logic        hold_pending = 1'b0;
    logic [7:0]  prev_data    = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: sync, low WB bytes of each metric MSB first, XOR of payload
    task automatic push_frame(input logic [255:0] s, input logic [255:0] c,
                              input logic [255:0] a, input logic [255:0] m);
        logic [255:0] v[4];
        logic [7:0]   b;
        logic [7:0]   x;
        v[0] = s; v[1] = c; v[2] = a; v[3] = m;
        x = '0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < int'(WB); k++) begin
                b = v[i][(int'(WB) - 1 - k) * 8 +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        exp_q.push_back(x);
    endtask

    // One clock: score the pending handshake, check hold rules, advance, sample #1 later
    task automatic step();
        logic [7:0] e;
        logic       v0;
        if (!reset && tx_valid_out && tx_ready_in) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_byte got=%0h expected=none", tx_data_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame_byte", 64'(tx_data_out), 64'(e));
            end
        end
        if (hold_pending && !reset) begin
            check("hold_valid", 64'(tx_valid_out), 64'(1));
            check("hold_data", 64'(tx_data_out), 64'(prev_data));
        end
        hold_pending = tx_valid_out && !tx_ready_in && !reset;
        prev_data    = tx_data_out;
        if (done_out) done_cnt++;
        v0 = tx_valid_out;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_valid_out && !v0) begin
            starts_seen++;
            start_cyc.push_back(cyc);
        end
    endtask

    task automatic set_basic();
        stall_count_in      = 256'h12;
        cpi_q78_in          = 256'h0280;
        arith_count_in      = 256'h1000;
        mem_access_count_in = 256'h0305;
    endtask

    task automatic drain_and_finish(input string tag);
        for (int k = 0; k < 200 && (exp_q.size() != 0 || busy_out); k++) step();
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_idle"}, 64'(busy_out), 64'(0));
    endtask

    initial begin
        reset = 1'b1; trigger_in = 1'b0; tx_ready_in = 1'b1;
        stall_count_in = '0; cpi_q78_in = '0; arith_count_in = '0; mem_access_count_in = '0;
        done_cnt = 0; starts_seen = 0;
        step(); step();
        check("rst_valid", 64'(tx_valid_out), 64'(0));
        check("rst_busy", 64'(busy_out), 64'(0));
        check("rst_done", 64'(done_out), 64'(0));
        check("rst_data", 64'(tx_data_out), 64'(0));
        check("rst_ovf", 64'(overflow_out), 64'(0));
        check("rst_missed", 64'(missed_trigger_out), 64'(0));
        reset = 1'b0;
        step();

        // Basic frame at full rate
        set_basic();
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        check("basic_cksum_model", 64'(exp_q[17]), 64'(8'h86));
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        check("basic_first_valid", 64'(tx_valid_out), 64'(1));
        check("basic_first_busy", 64'(busy_out), 64'(1));
        check("basic_first_sync", 64'(tx_data_out), 64'(8'hA5));
        done_cnt = 0;
        for (int k = 0; k < 18; k++) step();
        check("basic_all_sent", 64'(exp_q.size()), 64'(0));
        check("basic_done_pulse", 64'(done_out), 64'(1));
        check("basic_done_novalid", 64'(tx_valid_out), 64'(0));
        check("basic_done_busy", 64'(busy_out), 64'(1));
        check("basic_ovf", 64'(overflow_out), 64'(0));
        step();
        check("basic_done_once", 64'(done_out), 64'(0));
        check("basic_back_idle", 64'(busy_out), 64'(0));

        // Backpressure with ready pattern 1,0,0,1
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            tx_ready_in = ((k % 4) == 0) || ((k % 4) == 3);
            if (busy_out && !done_out) check("bp_valid_held", 64'(tx_valid_out), 64'(1));
            step();
        end
        check("bp_drained", 64'(exp_q.size()), 64'(0));
        check("bp_done", 64'(done_out), 64'(1));
        tx_ready_in = 1'b1;
        step();

        // Snapshot isolation: inputs change right after the latch edge
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        stall_count_in = 256'hFFFF; cpi_q78_in = 256'hFFFF;
        arith_count_in = 256'hFFFF; mem_access_count_in = 256'hFFFF;
        drain_and_finish("iso");

        // Overflow plus a trigger dropped mid-frame
        set_basic();
        stall_count_in = 256'd1 << 40;
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        trigger_in = 1'b1;
        starts_seen = 0;
        step();
        trigger_in = 1'b0;
        check("ovf_set", 64'(overflow_out), 64'(1));
        check("ovf_no_missed_yet", 64'(missed_trigger_out), 64'(0));
        for (int k = 0; k < 5; k++) step();
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        check("missed_set", 64'(missed_trigger_out), 64'(1));
        drain_and_finish("ovf");
        for (int k = 0; k < 6; k++) step();
        check("ovf_one_frame", 64'(starts_seen), 64'(1));
        check("missed_sticky", 64'(missed_trigger_out), 64'(1));
        check("ovf_holds", 64'(overflow_out), 64'(1));

        // Reset during byte 7
        set_basic();
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        step();
        exp_q.delete();
        check("mid_rst_valid", 64'(tx_valid_out), 64'(0));
        check("mid_rst_busy", 64'(busy_out), 64'(0));
        check("mid_rst_missed", 64'(missed_trigger_out), 64'(0));
        check("mid_rst_ovf", 64'(overflow_out), 64'(0));
        reset = 1'b0;
        step();
        check("mid_rst_no_resume", 64'(tx_valid_out), 64'(0));
        push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        check("after_rst_sync", 64'(tx_data_out), 64'(8'hA5));
        drain_and_finish("after_rst");

        // Back-to-back with trigger held high
        for (int f = 0; f < 3; f++)
            push_frame(stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in);
        start_cyc.delete();
        starts_seen = 0;
        done_cnt = 0;
        trigger_in = 1'b1;
        for (int k = 0; k < 200 && starts_seen < 3; k++) step();
        trigger_in = 1'b0;
        drain_and_finish("b2b");
        check("b2b_frames", 64'(starts_seen), 64'(3));
        if (start_cyc.size() >= 3) begin
            check("b2b_gap1", 64'(start_cyc[1] - start_cyc[0]), 64'(20));
            check("b2b_gap2", 64'(start_cyc[2] - start_cyc[1]), 64'(20));
        end
        check("b2b_done_count", 64'(done_cnt), 64'(3));
        check("b2b_missed", 64'(missed_trigger_out), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
